// File: rtl/ms_par_dsc_mul.sv
`default_nettype none
// ============================================================================
// Module   : ms_par_dsc_mul
// Brief    : Parallel-bitstream deterministic stochastic multiplier. Emits
//            P = 2^LOG2_PAR stream bit-pairs per cycle (unary A stream,
//            clock-divided B stream) and accumulates their AND count, which
//            equals A*B exactly after the sweep.
// Revision : 1.0 - initial release
// ============================================================================
module ms_par_dsc_mul #(
    parameter int DATA_WIDTH = 5,
    parameter int LOG2_PAR   = 2,
    parameter int EARLY_TERM = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a_in,
    input  logic [DATA_WIDTH-1:0]     b_in,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int W   = DATA_WIDTH;
    localparam int PAR = 1 << LOG2_PAR;

    // P expressed in the widths it is compared / added at.
    localparam logic [W:0]        PAR_WIDE = (W+1)'(PAR);
    localparam logic [LOG2_PAR:0] PAR_INC  = (LOG2_PAR+1)'(PAR);
    // a_ctr step; wraps to 0 when P == 2^W, so every cycle is a row end.
    localparam logic [W-1:0]      A_STEP   = W'(PAR);
    localparam logic [W-1:0]      ROW_END  = W'((1 << W) - PAR);
    localparam logic [W-1:0]      CTR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      a_ctr;
    logic [W-1:0]      b_ctr;
    logic [2*W-1:0]    acc;

    logic [W-1:0]      a_remain;
    logic [LOG2_PAR:0] pop_inc;
    logic              sb;
    logic              row_end;
    logic              last_b_row;
    logic              run_exit;
    logic              zero_op;
    logic [2*W-1:0]    acc_next;

    // Popcount of this cycle's P AND-ed bit pairs. The unary A stream makes
    // the ones contiguous, so the count is min(P, max(0, a_reg - a_ctr)).
    always_comb begin
        a_remain   = (a_reg > a_ctr) ? (a_reg - a_ctr) : '0;
        pop_inc    = ({1'b0, a_remain} >= PAR_WIDE) ? PAR_INC
                                                    : (LOG2_PAR+1)'(a_remain);
        sb         = (b_ctr < b_reg);
        acc_next   = acc + (sb ? (2*W)'(pop_inc) : '0);
        row_end    = (a_ctr == ROW_END);
        last_b_row = (({1'b0, b_ctr} + (W+1)'(1)) == {1'b0, b_reg});
        run_exit   = row_end && (((EARLY_TERM != 0) && last_b_row) ||
                                 (b_ctr == CTR_MAX));
        zero_op    = (EARLY_TERM != 0) && ((a_in == '0) || (b_in == '0));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = zero_op ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (run_exit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, stream counters, accumulator and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            a_ctr   <= '0;
            b_ctr   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (start) begin
                    a_reg <= a_in;
                    b_reg <= b_in;
                    a_ctr <= '0;
                    b_ctr <= '0;
                    acc   <= '0;
                    // Short-circuited zero operand: result is known now.
                    if (zero_op) begin
                        product <= '0;
                    end
                end
            end else if (state == S_RUN) begin
                acc   <= acc_next;
                a_ctr <= a_ctr + A_STEP;
                if (row_end) begin
                    b_ctr <= b_ctr + W'(1);
                end
                if (run_exit) begin
                    product <= acc_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ms_par_dsc_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_ms_par_dsc_mul
// Brief    : Directed self-checking bench for ms_par_dsc_mul; four instances
//            cover P=4/EARLY_TERM=1, P=4/EARLY_TERM=0, P=1 and P=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ms_par_dsc_mul;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] a_in = '0;
    logic [4:0] b_in = '0;
    logic [3:0] start_v = '0;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [9:0] prod_v [4];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // Per-instance configuration: LOG2_PAR and EARLY_TERM.
    int lp_of [4] = '{2, 2, 0, 5};
    int et_of [4] = '{1, 0, 1, 1};

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    ms_par_dsc_mul #(.DATA_WIDTH(5), .LOG2_PAR(2), .EARLY_TERM(1)) u_p4_et1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_in(a_in), .b_in(b_in),
        .busy(busy_v[0]), .done(done_v[0]), .product(prod_v[0]));
    ms_par_dsc_mul #(.DATA_WIDTH(5), .LOG2_PAR(2), .EARLY_TERM(0)) u_p4_et0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_in(a_in), .b_in(b_in),
        .busy(busy_v[1]), .done(done_v[1]), .product(prod_v[1]));
    ms_par_dsc_mul #(.DATA_WIDTH(5), .LOG2_PAR(0), .EARLY_TERM(1)) u_p1_et1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_in(a_in), .b_in(b_in),
        .busy(busy_v[2]), .done(done_v[2]), .product(prod_v[2]));
    ms_par_dsc_mul #(.DATA_WIDTH(5), .LOG2_PAR(5), .EARLY_TERM(1)) u_p32_et1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a_in(a_in), .b_in(b_in),
        .busy(busy_v[3]), .done(done_v[3]), .product(prod_v[3]));

    typedef struct {
        int idx;
        int a;
        int b;
        int prod;
        int lat;
    } vec_t;

    vec_t vecs [10];

    function automatic int exp_lat(input int a, input int b, input int idx);
        int p;
        p = 1 << lp_of[idx];
        if (et_of[idx] != 0 && (a == 0 || b == 0)) return 1;
        if (et_of[idx] != 0) return 1 + (b * 32) / p;
        return 1 + 1024 / p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Issue a one-cycle start; returns the cycle count right after the start edge.
    task automatic start_op(input int idx, input int a, input int b, output int t0);
        @(negedge clk);
        a_in = 5'(a);
        b_in = 5'(b);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start_v[idx] = 1'b0;
    endtask

    // Bounded wait for done; latency -1 means it never came.
    task automatic wait_done(input int idx, input int t0, output int lat);
        lat = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done_v[idx]) begin
                lat = cyc - t0 + 1;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input int idx, input int a, input int b,
                          input int exp_prod, input int exp_l);
        int t0;
        int lat;
        start_op(idx, a, b, t0);
        wait_done(idx, t0, lat);
        chk({name, "_lat"}, lat, exp_l);
        chk({name, "_prod"}, int'(prod_v[idx]), exp_prod);
        chk({name, "_busy_at_done"}, int'(busy_v[idx]), 1);
        @(posedge clk);
        #1;
        chk({name, "_done_fall"}, int'(done_v[idx]), 0);
        chk({name, "_busy_fall"}, int'(busy_v[idx]), 0);
    endtask

    initial begin
        int t0;
        int lat;
        int seen;
        int bl0 [5] = '{0, 1, 2, 7, 31};
        int al2 [5] = '{0, 1, 5, 16, 31};
        int bl2 [4] = '{0, 1, 3, 31};

        vecs[0] = '{idx: 0, a: 0,  b: 17, prod: 0,   lat: 1};
        vecs[1] = '{idx: 0, a: 17, b: 0,  prod: 0,   lat: 1};
        vecs[2] = '{idx: 0, a: 20, b: 13, prod: 260, lat: 105};
        vecs[3] = '{idx: 0, a: 31, b: 31, prod: 961, lat: 249};
        vecs[4] = '{idx: 0, a: 1,  b: 1,  prod: 1,   lat: 9};
        vecs[5] = '{idx: 1, a: 0,  b: 17, prod: 0,   lat: 257};
        vecs[6] = '{idx: 1, a: 31, b: 31, prod: 961, lat: 257};
        vecs[7] = '{idx: 2, a: 20, b: 13, prod: 260, lat: 417};
        vecs[8] = '{idx: 3, a: 20, b: 13, prod: 260, lat: 14};
        vecs[9] = '{idx: 3, a: 31, b: 31, prod: 961, lat: 32};

        // Reset state of every instance.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_busy%0d", i), int'(busy_v[i]), 0);
            chk($sformatf("rst_done%0d", i), int'(done_v[i]), 0);
            chk($sformatf("rst_prod%0d", i), int'(prod_v[i]), 0);
        end
        rst_n = 1'b1;

        // Directed table; rows 3 and 4 are back-to-back on the same instance.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b,
                   vecs[i].prod, vecs[i].lat);
        end

        // Start pulse mid-run with different operand is ignored.
        start_op(1, 3, 2, t0);
        repeat (49) @(posedge clk);
        @(negedge clk);
        a_in = 5'd9;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        wait_done(1, t0, lat);
        chk("ign_start_lat", lat, 257);
        chk("ign_start_prod", int'(prod_v[1]), 6);

        // Asynchronous reset mid-run aborts with no done pulse.
        start_op(0, 20, 13, t0);
        repeat (39) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_done", int'(done_v[0]), 0);
        chk("abort_prod", int'(prod_v[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (done_v[0]) seen++;
        end
        chk("abort_no_done", seen, 0);
        run_op("post_rst", 0, 5, 6, 30, 49);

        // Exhaustive sweep at P=32.
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                run_op($sformatf("sw3_%0d_%0d", a, b), 3, a, b, a * b, exp_lat(a, b, 3));
            end
        end
        // Every A against selected B at P=4.
        for (int a = 0; a < 32; a++) begin
            for (int j = 0; j < 5; j++) begin
                run_op($sformatf("sw0_%0d_%0d", a, bl0[j]), 0, a, bl0[j],
                       a * bl0[j], exp_lat(a, bl0[j], 0));
            end
        end
        // Selected corners at P=1.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                run_op($sformatf("sw2_%0d_%0d", al2[i], bl2[j]), 2, al2[i], bl2[j],
                       al2[i] * bl2[j], exp_lat(al2[i], bl2[j], 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
